// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receive path: FSM encoding, register map,
// status bit layout and oversampling constants.
package uart_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_START = 2'd1,
      ST_DATA  = 2'd2,
      ST_STOP  = 2'd3
   } rx_state_e;

   localparam logic ADDR_DATA = 1'b0;
   localparam logic ADDR_STAT = 1'b1;

   localparam int STAT_FULL   = 7;
   localparam int STAT_OVR    = 6;
   localparam int STAT_FERR   = 5;
   localparam int STAT_IRQ_EN = 0;

   localparam int         OVERSAMPLE = 16;
   localparam logic [3:0] MID_TICK   = 4'd8;
   localparam logic [3:0] LAST_TICK  = 4'(OVERSAMPLE - 1);

   function automatic logic [7:0] pack_status(input logic full, input logic ovr,
                                              input logic ferr, input logic irq_en);
      logic [7:0] st;
      st              = 8'h00;
      st[STAT_FULL]   = full;
      st[STAT_OVR]    = ovr;
      st[STAT_FERR]   = ferr;
      st[STAT_IRQ_EN] = irq_en;
      return st;
   endfunction

endpackage

// File: rtl/baud_tick.sv
// 16x oversample tick generator: one-CLK pulse every DIV cycles, restartable by clr.
module baud_tick #(
   parameter int DIV   = 13,
   parameter int DIV_W = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   output logic tick
);

   localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(DIV - 1);

   logic [DIV_W-1:0] cnt_q, cnt_d;
   logic             tick_q, tick_d;

   // next divider count and tick pulse
   always_comb begin
      cnt_d  = cnt_q;
      tick_d = 1'b0;
      if (clr) begin
         cnt_d  = {DIV_W{1'b0}};
         tick_d = 1'b0;
      end else if (cnt_q == CNT_LAST) begin
         cnt_d  = {DIV_W{1'b0}};
         tick_d = 1'b1;
      end else begin
         cnt_d  = cnt_q + DIV_W'(1);
         tick_d = 1'b0;
      end
   end

   // divider state
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q  <= {DIV_W{1'b0}};
         tick_q <= 1'b0;
      end else begin
         cnt_q  <= cnt_d;
         tick_q <= tick_d;
      end
   end

   assign tick = tick_q;

endmodule

// File: rtl/uart_rx.sv
// Memory-mapped 8N1 receiver with single-byte holding register and status flags.
// Optional receive interrupt enable is built when UART_RX_IRQ_EN is defined.
module uart_rx
   import uart_pkg::*;
#(
   parameter int DIV   = 13,
   parameter int DIV_W = 4
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       RXD,
   input  logic       ADDR,
   input  logic       R,
   input  logic       W,
   input  logic [7:0] DIN,
   output logic [7:0] DOUT,
   output logic       IRQ
);

   logic       rxd_s1_q, rxd_s2_q, rxd_prev_q;
   rx_state_e  state_q, state_d;
   logic [3:0] sub_q, sub_d;
   logic [2:0] bit_q, bit_d;
   logic [7:0] shift_q, shift_d;
   logic [7:0] data_q, data_d;
   logic       full_q, full_d, ovr_q, ovr_d, ferr_q, ferr_d;
   logic       rd_low_q, rd_low_d, addr_lat_q, addr_lat_d;
   logic       tick_s, tick_clr_s, deliver_s, fall_s, rd_clr_s, irq_en_s;
   logic       unused_s;

   assign fall_s = rxd_prev_q & ~rxd_s2_q;

   baud_tick #(.DIV(DIV), .DIV_W(DIV_W)) u_tick (
      .clk   (CLK),
      .rst_n (RESET),
      .clr   (tick_clr_s),
      .tick  (tick_s)
   );

   // receive FSM: sub counts ticks within a bit, bit counts data bits
   always_comb begin
      state_d    = state_q;
      sub_d      = sub_q;
      bit_d      = bit_q;
      shift_d    = shift_q;
      tick_clr_s = 1'b0;
      deliver_s  = 1'b0;
      if (tick_s) begin
         sub_d = sub_q + 4'd1;
      end else begin
         sub_d = sub_q;
      end
      case (state_q)
         ST_IDLE: begin
            if (fall_s) begin
               tick_clr_s = 1'b1;
               sub_d      = 4'd0;
               bit_d      = 3'd0;
               state_d    = ST_START;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_START: begin
            if (tick_s && (sub_q == MID_TICK - 4'd1)) begin
               sub_d   = 4'd0;
               state_d = rxd_s2_q ? ST_IDLE : ST_DATA;
            end else begin
               state_d = ST_START;
            end
         end
         ST_DATA: begin
            if (tick_s && (sub_q == LAST_TICK)) begin
               shift_d = {rxd_s2_q, shift_q[7:1]};
               bit_d   = bit_q + 3'd1;
               state_d = (bit_q == 3'd7) ? ST_STOP : ST_DATA;
            end else begin
               state_d = ST_DATA;
            end
         end
         ST_STOP: begin
            if (tick_s && (sub_q == LAST_TICK)) begin
               deliver_s = 1'b1;
               state_d   = ST_IDLE;
            end else begin
               state_d = ST_STOP;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // read-end detection: first CLK with R high after R was low, on the latched address
   always_comb begin
      rd_low_d   = ~R;
      addr_lat_d = R ? addr_lat_q : ADDR;
      rd_clr_s   = R & rd_low_q & (addr_lat_q == ADDR_DATA);
   end

   // holding register and flags; a read-clear coinciding with delivery frees the slot
   always_comb begin
      data_d = data_q;
      full_d = full_q;
      ovr_d  = ovr_q;
      ferr_d = ferr_q;
      if (deliver_s) begin
         if (!full_q || rd_clr_s) begin
            data_d = shift_q;
            full_d = 1'b1;
            ferr_d = ~rxd_s2_q;
            ovr_d  = rd_clr_s ? 1'b0 : ovr_q;
         end else begin
            ovr_d = 1'b1;
         end
      end else if (rd_clr_s) begin
         full_d = 1'b0;
         ovr_d  = 1'b0;
         ferr_d = 1'b0;
      end else begin
         data_d = data_q;
      end
   end

   // state and register flops
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rxd_s1_q   <= 1'b1;
         rxd_s2_q   <= 1'b1;
         rxd_prev_q <= 1'b1;
         state_q    <= ST_IDLE;
         sub_q      <= 4'd0;
         bit_q      <= 3'd0;
         shift_q    <= 8'h00;
         data_q     <= 8'h00;
         full_q     <= 1'b0;
         ovr_q      <= 1'b0;
         ferr_q     <= 1'b0;
         rd_low_q   <= 1'b0;
         addr_lat_q <= 1'b0;
      end else begin
         rxd_s1_q   <= RXD;
         rxd_s2_q   <= rxd_s1_q;
         rxd_prev_q <= rxd_s2_q;
         state_q    <= state_d;
         sub_q      <= sub_d;
         bit_q      <= bit_d;
         shift_q    <= shift_d;
         data_q     <= data_d;
         full_q     <= full_d;
         ovr_q      <= ovr_d;
         ferr_q     <= ferr_d;
         rd_low_q   <= rd_low_d;
         addr_lat_q <= addr_lat_d;
      end
   end

`ifdef UART_RX_IRQ_EN
   logic irq_en_q, irq_en_d;

   // control write on ADDR 1 loads the interrupt enable
   always_comb begin
      if (!W && (ADDR == ADDR_STAT)) begin
         irq_en_d = DIN[0];
      end else begin
         irq_en_d = irq_en_q;
      end
   end

   // interrupt enable flop
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         irq_en_q <= 1'b0;
      end else begin
         irq_en_q <= irq_en_d;
      end
   end

   assign irq_en_s = irq_en_q;
`else
   assign irq_en_s = 1'b0;
`endif

   assign unused_s = ^{W, DIN};
   assign IRQ      = full_q & irq_en_s;

   // CPU read mux
   always_comb begin
      case (ADDR)
         ADDR_DATA: DOUT = data_q;
         ADDR_STAT: DOUT = pack_status(full_q, ovr_q, ferr_q, irq_en_s);
         default:   DOUT = 8'h00;
      endcase
   end

endmodule
